cam_param: RTL and testbench
============================

# cam_param

Parametrised content-addressable memory that succeeds the fixed 16-entry, 7-bit CAM. It adds configurable key width and depth, explicit search, write, delete and clear operations, and valid bits per entry. It also reports a registered, priority-encoded hit index with a multi-hit flag. It sits behind the Tiny Tapeout `tt_um_*` wrapper and is driven from `ui_in`/`uio_in`; responses go to `uo_out`/`uio_out`.

## Interface
- `KEY_W`, default 7: key width in bits, valid range 1..32.
- `DEPTH`, default 16: number of entries, power of two, 2..64.
- `IDX_W`, default `$clog2(DEPTH)`: index width (derived, not overridden).

- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `op_valid`, input, 1: operation request.
- `op`, input, 2: 00 SEARCH, 01 WRITE, 10 DELETE, 11 CLEAR.
- `key`, input, `KEY_W`: operand key.
- `rsp_valid`, output, 1: response strobe, one cycle per request.
- `hit`, output, 1: key matched at least one valid entry.
- `hit_idx`, output, `IDX_W`: lowest matching index; for WRITE, the index written.
- `multi_hit`, output, 1: more than one valid entry matched.
- `match_vec`, output, `DEPTH`: one-hot/multi-hot match vector.
- `full`, output, 1: all entries valid (combinational from the valid bits).
- `err`, output, 1: WRITE rejected.

## Operation
- **Storage:** `DEPTH` × `KEY_W` key registers plus `DEPTH` valid bits. Keys are never reset; valid bits reset to 0.
- **No back-pressure:** a request is accepted every cycle `op_valid` = 1.
- **Two-stage pipeline:**
  - Stage 1 registers `match_vec_q` = `valid & (entry == key)` and the op code.
  - Stage 2 priority-encodes the result and registers all response outputs.
- **SEARCH:** no state change. Response returns `hit`, `hit_idx`, `multi_hit` and `match_vec`.
- **WRITE:**
  - If the key is already present, there is no storage change; the response has `hit` = 1 and `hit_idx` = the existing index.
  - Otherwise the key is stored in the lowest invalid entry and its valid bit is set; the response has `hit` = 0 and `hit_idx` = the written index.
  - If full and the key is absent, the behaviour is set under Configuration.
- **DELETE:** clears the valid bit of every matching entry in the accept cycle. Response reports the pre-delete match.
- **CLEAR:** clears all valid bits in the accept cycle. Response has `hit` = 0 and `match_vec` = 0.
- **Write visibility:** the storage/valid update happens at the end of the accept cycle. Any operation accepted in the next cycle sees it, so there are no read-after-write hazards.
- **Multi-hit:** only reachable after an external duplicate condition, such as `KEY_W` truncation at integration. The lowest index wins.
- **Width rules:** `hit_idx` is `IDX_W` wide; `hit_idx` = 0 when `hit` = 0 on SEARCH and DELETE.

## Timing
- **Latency:** request in cycle N gives `rsp_valid` in cycle N+2, fully pipelined at one operation per cycle.
- **Output registers:** all response outputs are registered. They hold their last value when `rsp_valid` = 0.
- **Reset values:** `rsp_valid`, `hit`, `hit_idx`, `multi_hit`, `match_vec` and `err` are all 0. `full` is 0 and the valid bits are 0.
- **Reset mid-operation:** in-flight responses are discarded. No `rsp_valid` is produced for requests accepted before reset.
- **Back-to-back same key:** a WRITE at N followed by a SEARCH at N+1 gives the SEARCH a hit.
- **DELETE then WRITE of the same key in consecutive cycles:** the WRITE allocates the lowest free entry, which may be the just-freed one.

## Configuration
- **`CAM_REPLACE_EN` defined:** a WRITE with the CAM full and the key absent overwrites the entry at a round-robin victim pointer. The pointer is `IDX_W` bits, resets to 0 and increments modulo `DEPTH` on each replacement. The response gives `hit` = 0, `err` = 0 and `hit_idx` = the victim.
- **`CAM_REPLACE_EN` undefined:** that WRITE is dropped with no state change. The response gives `err` = 1, `hit` = 0 and `hit_idx` = 0. The victim pointer logic is absent.

## Structure
- **`cam_pkg`:** op-code enum `cam_op_t` (SEARCH/WRITE/DELETE/CLEAR) and the op-code width constant.
- **Sub-module `cam_prio_enc`:** parameterised by `DEPTH`. Input is the match vector; outputs are `any`, lowest index and `multi`. It is instantiated twice: once for the match vector and once for the inverted valid bits, for free-slot search.
- **Top module `cam_param`:** contains the storage, comparators, pipeline registers and victim pointer.

## Test plan
- **Reset then SEARCH:** reset, then SEARCH `key` = 0x2A → at N+2, `rsp_valid` = 1, `hit` = 0, `match_vec` = 0, `full` = 0.
- **WRITE then SEARCH:** WRITE 0x11, 0x22, 0x33 back-to-back, then SEARCH 0x22 → write responses have `hit_idx` 0, 1, 2; the search gives `hit` = 1, `hit_idx` = 1, `match_vec` = 16'h0002.
- **Duplicate WRITE:** WRITE 0x11 again → `hit` = 1, `hit_idx` = 0, and valid-entry count is unchanged.
- **DELETE and reuse:** DELETE 0x22, then SEARCH 0x22 → `hit` = 0. A following WRITE 0x44 → `hit_idx` = 1.
- **Fill, overflow, clear:** fill 16 entries so `full` = 1, then WRITE 0x7F:
  - with `CAM_REPLACE_EN`: `hit_idx` = 0, `err` = 0;
  - without it: `err` = 1.
  - CLEAR then gives `full` = 0.
- **Reset mid-pipeline:** assert `rst` in the cycle after SEARCH → no `rsp_valid`, all outputs 0, valid bits cleared.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types for the parametrised CAM: op-code encoding and its width.
package cam_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SEARCH = 2'b00,
    OP_WRITE  = 2'b01,
    OP_DELETE = 2'b10,
    OP_CLEAR  = 2'b11
  } cam_op_t;

endpackage

// File: rtl/cam_param_if.sv
// Request/response bundle for cam_param. The master drives op_valid/op/key and
// samples the registered response; there is no back-pressure.
interface cam_param_if #(
  parameter int KEY_W = 7,
  parameter int DEPTH = 16
);
  import cam_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  // Handshake: a request is taken on every rising edge with op_valid = 1 (no
  // ready); exactly one rsp_valid pulse follows two cycles later, in order.
  logic             op_valid;
  cam_op_t          op;
  logic [KEY_W-1:0] key;
  logic             rsp_valid;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             multi_hit;
  logic [DEPTH-1:0] match_vec;
  logic             full;
  logic             err;

  modport master (
    output op_valid, op, key,
    input  rsp_valid, hit, hit_idx, multi_hit, match_vec, full, err
  );

  modport slave (
    input  op_valid, op, key,
    output rsp_valid, hit, hit_idx, multi_hit, match_vec, full, err
  );

endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder with any/multi flags; used for hit reporting
// and for locating the lowest free CAM entry.
module cam_prio_enc #(
  parameter  int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] i_vec,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_multi
);

  // Scan from the top so the lowest set bit is the last assignment.
  always_comb begin
    o_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

  assign o_any   = |i_vec;
  assign o_multi = |(i_vec & (i_vec - DEPTH'(1)));

endmodule

// File: rtl/cam_param.sv
// Parametrised CAM: two-stage search/write/delete/clear pipeline.
// Define CAM_REPLACE_EN to overwrite a round-robin victim when full.
module cam_param
  import cam_pkg::*;
#(
  parameter  int KEY_W = 7,
  parameter  int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  cam_param_if.slave  bus
);

  logic [KEY_W-1:0] r_key [DEPTH];
  logic [DEPTH-1:0] r_valid;

  logic [DEPTH-1:0] w_match;
  logic             w_hit1;
  logic             w_free_any;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_unused_free_multi;
  logic             w_wr_new;
  logic             w_store;
  logic             w_wr_err;
  logic [IDX_W-1:0] w_wr_idx;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_valid[i] && (r_key[i] == bus.key);
    end
  end

  assign w_hit1 = |w_match;

  cam_prio_enc #(.DEPTH(DEPTH)) u_free_enc (
    .i_vec   (~r_valid),
    .o_any   (w_free_any),
    .o_idx   (w_free_idx),
    .o_multi (w_unused_free_multi)
  );

  assign w_wr_new = bus.op_valid && (bus.op == OP_WRITE) && !w_hit1;

`ifdef CAM_REPLACE_EN
  logic [IDX_W-1:0] r_victim;

  assign w_store  = w_wr_new;
  assign w_wr_err = 1'b0;
  assign w_wr_idx = w_free_any ? w_free_idx : r_victim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_victim <= '0;
    end else if (w_wr_new && !w_free_any) begin
      r_victim <= r_victim + IDX_W'(1);
    end
  end
`else
  assign w_store  = w_wr_new && w_free_any;
  assign w_wr_err = w_wr_new && !w_free_any;
  assign w_wr_idx = w_free_any ? w_free_idx : '0;
`endif

  // Key storage carries no reset; only the valid bits define occupancy.
  always_ff @(posedge clk) begin
    if (w_store) r_key[w_wr_idx] <= bus.key;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (bus.op_valid) begin
      case (bus.op)
        OP_WRITE:  if (w_store) r_valid[w_wr_idx] <= 1'b1;
        OP_DELETE: r_valid <= r_valid & ~w_match;
        OP_CLEAR:  r_valid <= '0;
        default:   ;
      endcase
    end
  end

  // Stage 1: match vector plus the write outcome decided in the accept cycle.
  logic             r_vld_q;
  logic [DEPTH-1:0] r_match_q;
  logic [IDX_W-1:0] r_wr_idx_q;
  logic             r_wr_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_q    <= 1'b0;
      r_match_q  <= '0;
      r_wr_idx_q <= '0;
      r_wr_err_q <= 1'b0;
    end else begin
      r_vld_q    <= bus.op_valid;
      r_match_q  <= (bus.op == OP_CLEAR) ? '0 : w_match;
      r_wr_idx_q <= w_store ? w_wr_idx : '0;
      r_wr_err_q <= w_wr_err;
    end
  end

  // Stage 2: priority-encode and register the response.
  logic             w_any;
  logic [IDX_W-1:0] w_idx;
  logic             w_multi;

  cam_prio_enc #(.DEPTH(DEPTH)) u_hit_enc (
    .i_vec   (r_match_q),
    .o_any   (w_any),
    .o_idx   (w_idx),
    .o_multi (w_multi)
  );

  logic             r_rsp_valid;
  logic             r_hit;
  logic [IDX_W-1:0] r_hit_idx;
  logic             r_multi_hit;
  logic [DEPTH-1:0] r_match_vec;
  logic             r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_hit_idx   <= '0;
      r_multi_hit <= 1'b0;
      r_match_vec <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= r_vld_q;
      if (r_vld_q) begin
        r_hit       <= w_any;
        r_hit_idx   <= w_any ? w_idx : r_wr_idx_q;
        r_multi_hit <= w_multi;
        r_match_vec <= r_match_q;
        r_err       <= r_wr_err_q;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.hit       = r_hit;
  assign bus.hit_idx   = r_hit_idx;
  assign bus.multi_hit = r_multi_hit;
  assign bus.match_vec = r_match_vec;
  assign bus.err       = r_err;
  assign bus.full      = &r_valid;

endmodule

// File: tb/tb_cam_param.sv
// Bench for cam_param: directed plan plus random ops against a table model;
// expected responses are queued at issue and popped by a response monitor.
module tb_cam_param;
  import cam_pkg::*;

  localparam int KEY_W = 7;
  localparam int DEPTH = 16;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int RW    = 1 + IDX_W + 1 + DEPTH + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cam_param_if #(.KEY_W(KEY_W), .DEPTH(DEPTH)) bus ();

  cam_param #(.KEY_W(KEY_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  // Reference model: a table of keys with occupancy flags.
  logic [KEY_W-1:0] m_key [DEPTH];
  bit               m_val [DEPTH];
  int               m_victim = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
    m_victim = 0;
  endtask

  function automatic bit model_full();
    for (int i = 0; i < DEPTH; i++) if (!m_val[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_op(input logic [1:0] op, input logic [KEY_W-1:0] k,
                          output logic [RW-1:0] rsp);
    logic [DEPTH-1:0] mv;
    logic [IDX_W-1:0] idx;
    int cnt, low, free;
    logic hit, err;
    mv = '0; cnt = 0; low = -1; err = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_val[i] && m_key[i] == k) begin
        mv[i] = 1'b1;
        cnt++;
        if (low < 0) low = i;
      end
    end
    hit = (cnt > 0);
    idx = hit ? IDX_W'(low) : '0;
    case (op)
      2'b01: if (!hit) begin
        free = -1;
        for (int i = 0; i < DEPTH; i++) if (!m_val[i] && free < 0) free = i;
        if (free >= 0) begin
          m_key[free] = k;
          m_val[free] = 1'b1;
          idx = IDX_W'(free);
        end else begin
`ifdef CAM_REPLACE_EN
          m_key[m_victim] = k;
          idx = IDX_W'(m_victim);
          m_victim = (m_victim + 1) % DEPTH;
`else
          err = 1'b1;
`endif
        end
      end
      2'b10: for (int i = 0; i < DEPTH; i++) if (mv[i]) m_val[i] = 1'b0;
      2'b11: begin
        for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
        mv = '0; hit = 1'b0; idx = '0; cnt = 0;
      end
      default: ;
    endcase
    rsp = {hit, idx, (cnt > 1), mv, err};
  endtask

  task automatic issue(input logic [1:0] op, input logic [KEY_W-1:0] k);
    logic [RW-1:0] rsp;
    @(negedge clk);
    chk("full", {63'd0, bus.full}, {63'd0, model_full()});
    bus.op_valid = 1'b1;
    bus.op       = cam_op_t'(op);
    bus.key      = k;
    model_op(op, k, rsp);
    exp_q.push_back(rsp);
    exp_cyc_q.push_back(cyc + 2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("full", {63'd0, bus.full}, {63'd0, model_full()});
      bus.op_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_hit",       {63'd0, bus.hit},       64'd0);
    chk("rst_hit_idx",   64'(bus.hit_idx),       64'd0);
    chk("rst_multi_hit", {63'd0, bus.multi_hit}, 64'd0);
    chk("rst_match_vec", 64'(bus.match_vec),     64'd0);
    chk("rst_err",       {63'd0, bus.err},       64'd0);
    chk("rst_full",      {63'd0, bus.full},      64'd0);
  endtask

  // Monitor: every response pulse pops one expectation and checks its timing.
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        logic [RW-1:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("rsp", 64'({bus.hit, bus.hit_idx, bus.multi_hit, bus.match_vec, bus.err}), 64'(e));
        chk("latency", 64'(cyc), 64'(ec));
      end
    end
  end

  initial begin
    bus.op_valid = 1'b0;
    bus.op       = OP_SEARCH;
    bus.key      = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    issue(2'b00, 7'h2A);
    issue(2'b01, 7'h11);
    issue(2'b01, 7'h22);
    issue(2'b01, 7'h33);
    issue(2'b00, 7'h22);
    issue(2'b01, 7'h11);
    issue(2'b10, 7'h22);
    issue(2'b00, 7'h22);
    issue(2'b01, 7'h44);
    issue(2'b01, 7'h10);
    issue(2'b10, 7'h10);
    issue(2'b01, 7'h10);
    issue(2'b11, 7'h00);
    for (int i = 0; i < DEPTH; i++) issue(2'b01, KEY_W'(7'h50 + i));
    idle(1);
    issue(2'b01, 7'h7F);
    issue(2'b00, 7'h7F);
    issue(2'b00, 7'h51);
    issue(2'b11, 7'h00);
    idle(4);

    // Reset one cycle after a search is accepted: its response must vanish.
    issue(2'b01, 7'h11);
    idle(3);
    issue(2'b00, 7'h11);
    @(negedge clk);
    rst = 1'b1;
    bus.op_valid = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    issue(2'b00, 7'h11);
    idle(1);

    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 40)      issue(2'b01, KEY_W'($urandom_range(0, 19)));
      else if (r < 75) issue(2'b00, KEY_W'($urandom_range(0, 19)));
      else if (r < 95) issue(2'b10, KEY_W'($urandom_range(0, 19)));
      else             issue(2'b11, KEY_W'($urandom_range(0, 19)));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain_pending", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
